// File: rtl/riscv_v_mul_pipe.sv
// riscv_v_mul_pipe
// Pipelined packed-SIMD vector multiplier for the RISC-V V datapath.
// Supports vmul / vmulh / vmulhu / vmulhsu through is_high and the
// independent srca_signed / srcb_signed controls, over element widths
// 8, 16, 32 and 64 bits selected one-hot by osize_vector.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        input handshake
//   is_high                    1: upper EW bits of each product, 0: lower EW bits
//   srca_signed, srcb_signed   per-source two's complement interpretation
//   osize_vector               one-hot element width select (bit k -> EW = 8<<k)
//   srca, srcb                 packed operand vectors
//   in_tag                     sideband tag, returned unchanged on out_tag
//   out_valid / out_ready      output handshake
//   result                     packed per-element results
//   out_tag                    tag captured with the operation
//   out_err                    osize_vector was not one-hot (result forced to 0)
module riscv_v_mul_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_OSIZES = 4,
  parameter int NUM_STAGES = 3,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_high,
  input  logic                  srca_signed,
  input  logic                  srcb_signed,
  input  logic [NUM_OSIZES-1:0] osize_vector,
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  // Per-width packed results, all widths computed in parallel.
  logic [DATA_WIDTH-1:0] res_by_size [NUM_OSIZES];

  for (genvar k = 0; k < NUM_OSIZES; k++) begin : g_size
    localparam int EW = 8 << k;
    localparam int NE = DATA_WIDTH / EW;
    for (genvar e = 0; e < NE; e++) begin : g_elem
      logic [EW-1:0]   a, b;
      logic [2*EW-1:0] ax, bx, p;
      assign a  = srca[e*EW +: EW];
      assign b  = srcb[e*EW +: EW];
      // Extending straight to 2*EW bits and multiplying modulo 2^(2*EW)
      // yields the same low 2*EW bits as the (EW+1)-bit signed product.
      assign ax = {{EW{srca_signed & a[EW-1]}}, a};
      assign bx = {{EW{srcb_signed & b[EW-1]}}, b};
      assign p  = ax * bx;
      assign res_by_size[k][e*EW +: EW] = is_high ? p[2*EW-1:EW] : p[EW-1:0];
    end
  end

  logic                  osize_ok;
  logic [DATA_WIDTH-1:0] mul_res;

  always_comb begin
    osize_ok = (osize_vector != '0) &&
               ((osize_vector & (osize_vector - NUM_OSIZES'(1))) == '0);
    mul_res  = '0;
    if (osize_ok) begin
      for (int unsigned k = 0; k < NUM_OSIZES; k++) begin
        if (osize_vector[k]) mul_res = res_by_size[k];
      end
    end
  end

  // Pipeline: the full product is registered into stage 0; the remaining
  // stages are delay slots with per-stage bubble collapse.
  logic [NUM_STAGES-1:0] st_v;
  logic [DATA_WIDTH-1:0] st_res [NUM_STAGES];
  logic [TAG_WIDTH-1:0]  st_tag [NUM_STAGES];
  logic [NUM_STAGES-1:0] st_err;
  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] load;
  logic                  fire_in;

  // Advance chain runs from the output backwards, so out_ready reaches
  // in_ready combinationally.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES-1] = st_v[NUM_STAGES-1] & out_ready;
    for (int unsigned i = NUM_STAGES - 1; i > 0; i--) begin
      adv[i-1] = st_v[i-1] & (~st_v[i] | adv[i]);
    end
  end

  assign in_ready = ~rst & (~st_v[0] | adv[0]);
  assign fire_in  = in_valid & in_ready;

  always_comb begin
    load    = '0;
    load[0] = fire_in;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_v   <= '0;
      st_err <= '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        st_res[i] <= '0;
        st_tag[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        st_v[0]   <= 1'b1;
        st_res[0] <= mul_res;
        st_tag[0] <= in_tag;
        st_err[0] <= ~osize_ok;
      end else if (adv[0]) begin
        st_v[0] <= 1'b0;
      end
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        if (load[i]) begin
          st_v[i]   <= 1'b1;
          st_res[i] <= st_res[i-1];
          st_tag[i] <= st_tag[i-1];
          st_err[i] <= st_err[i-1];
        end else if (adv[i]) begin
          st_v[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st_v[NUM_STAGES-1];
  assign result    = st_res[NUM_STAGES-1];
  assign out_tag   = st_tag[NUM_STAGES-1];
  assign out_err   = st_err[NUM_STAGES-1];

endmodule

// File: tb/tb_riscv_v_mul_pipe.sv
// Scoreboard testbench for riscv_v_mul_pipe: the driver pushes hand-computed
// expectations on acceptance, an independent monitor pops and compares on
// every output transfer and checks that stalled outputs stay steady.
module tb_riscv_v_mul_pipe;

  localparam int DW = 64;
  localparam int NO = 4;
  localparam int NS = 3;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          is_high;
  logic          srca_signed;
  logic          srcb_signed;
  logic [NO-1:0] osize_vector;
  logic [DW-1:0] srca;
  logic [DW-1:0] srcb;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [TW-1:0] out_tag;
  logic          out_err;

  riscv_v_mul_pipe #(
    .DATA_WIDTH(DW),
    .NUM_OSIZES(NO),
    .NUM_STAGES(NS),
    .TAG_WIDTH (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_high     (is_high),
    .srca_signed (srca_signed),
    .srcb_signed (srcb_signed),
    .osize_vector(osize_vector),
    .srca        (srca),
    .srcb        (srcb),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_tag     (out_tag),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
    logic          lat_chk;
    int            acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   passed   = 0;
  int   total    = 0;
  int   cyc      = 0;
  int   accepted = 0;
  int   emitted  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops on transfer, checks stall stability.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_res;
  logic [TW-1:0] held_tag;
  logic          held_err;

  always @(negedge clk) begin
    exp_t e;
    if (stall_prev && !rst) begin
      check("stall_hold_result", result, held_res);
      check("stall_hold_tag", DW'(out_tag), DW'(held_tag));
      check("stall_hold_err", DW'(out_err), DW'(held_err));
    end
    if (out_valid && out_ready && !rst) begin
      emitted++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("out_tag", DW'(out_tag), DW'(e.tag));
        check("out_err", DW'(out_err), DW'(e.err));
        if (e.lat_chk) check("latency", DW'(cyc - e.acc_cyc), DW'(NS));
      end
    end
    stall_prev = out_valid && !out_ready && !rst;
    held_res   = result;
    held_tag   = out_tag;
    held_err   = out_err;
  end

  // Drive one operation; called just after a rising edge.
  task automatic issue(input logic [NO-1:0] osz, input logic hi, input logic as, input logic bs,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag,
                       input logic [DW-1:0] exp_res, input logic exp_err, input logic lat_chk);
    exp_t e;
    bit   done = 0;
    osize_vector = osz;
    is_high      = hi;
    srca_signed  = as;
    srcb_signed  = bs;
    srca         = a;
    srcb         = b;
    in_tag       = tag;
    in_valid     = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp_res; e.tag = tag; e.err = exp_err; e.lat_chk = lat_chk; e.acc_cyc = cyc;
        exp_q.push_back(e);
        accepted++;
        done = 1;
      end else if (!out_ready) begin
        // Backpressure may only appear once every stage holds an op.
        check("occupancy_at_stall", DW'(accepted - emitted), DW'(NS));
      end
      if (out_ready) check("in_ready_when_draining", DW'(in_ready), 1);
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    is_high = 1'b0; srca_signed = 1'b0; srcb_signed = 1'b0;
    osize_vector = 4'b0001; srca = '0; srcb = '0; in_tag = '0;
    idle(3);
    @(negedge clk);
    check("rst_in_ready", DW'(in_ready), 0);
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_out_tag", DW'(out_tag), 0);
    check("rst_out_err", DW'(out_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", DW'(in_ready), 1);
    @(posedge clk); #1;

    // EW=8 signedness combinations, byte0 = 0xFF * 0x02
    issue(4'b0001, 1, 1, 1, 64'hFF, 64'h02, 8'h01, 64'hFF, 0, 1); idle(NS + 1);
    issue(4'b0001, 1, 0, 0, 64'hFF, 64'h02, 8'h02, 64'h01, 0, 1); idle(NS + 1);
    issue(4'b0001, 1, 1, 0, 64'hFF, 64'h02, 8'h03, 64'hFF, 0, 1); idle(NS + 1);
    issue(4'b0001, 1, 0, 1, 64'hFF, 64'h02, 8'h04, 64'h01, 0, 1); idle(NS + 1);
    issue(4'b0001, 0, 1, 1, 64'hFF, 64'h02, 8'h05, 64'hFE, 0, 1); idle(NS + 1);
    issue(4'b0001, 0, 0, 0, 64'hFF, 64'h02, 8'h06, 64'hFE, 0, 1); idle(NS + 1);
    issue(4'b0001, 0, 1, 0, 64'hFF, 64'h02, 8'h07, 64'hFE, 0, 1); idle(NS + 1);
    // EW=16: 0xFFFF^2 unsigned = 0xFFFE0001, signed (-1)^2 = 1
    issue(4'b0010, 1, 0, 0, 64'hFFFF, 64'hFFFF, 8'h10, 64'hFFFE, 0, 1); idle(NS + 1);
    issue(4'b0010, 1, 1, 1, 64'hFFFF, 64'hFFFF, 8'h11, 64'h0000, 0, 1); idle(NS + 1);
    // EW=32: 2^16 * 2^16 = 2^32 per lane
    issue(4'b0100, 0, 0, 0, 64'h00010000_00010000, 64'h00010000_00010000, 8'h20, 64'h0, 0, 1); idle(NS + 1);
    issue(4'b0100, 1, 0, 0, 64'h00010000_00010000, 64'h00010000_00010000, 8'h21,
          64'h00000001_00000001, 0, 1); idle(NS + 1);
    // EW=64: -2^63 * -1 = +2^63
    issue(4'b1000, 1, 1, 1, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 8'h30, 64'h0, 0, 1); idle(NS + 1);
    issue(4'b1000, 0, 1, 1, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF, 8'h31,
          64'h80000000_00000000, 0, 1); idle(NS + 1);
    // Malformed osize: result zero, error flagged, tag kept
    issue(4'b0101, 0, 0, 0, 64'h1234, 64'h5678, 8'h5A, 64'h0, 1, 1); idle(NS + 1);
    issue(4'b0000, 1, 1, 1, 64'h1234, 64'h5678, 8'hA5, 64'h0, 1, 1); idle(NS + 1);

    // Back-to-back stream of 10 with a 4-cycle output stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] v;
          logic [7:0] r;
          v = 8'(i);
          r = 8'(3 * i);
          issue(4'b0001, 0, 0, 0, {8{v}}, {8{8'h03}}, v, {8{r}}, 0, 0);
        end
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(4);
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) idle(1);
    check("stream_drained", DW'(exp_q.size()), 0);
    check("stream_count", DW'(accepted - emitted), 0);

    // Reset with two ops in flight: both are dropped
    issue(4'b0001, 0, 0, 0, 64'h01, 64'h01, 8'hE1, 64'h01, 0, 0);
    issue(4'b0001, 0, 0, 0, 64'h02, 64'h01, 8'hE2, 64'h02, 0, 0);
    rst = 1'b1;
    e0 = emitted;
    @(negedge clk);
    check("in_ready_during_rst", DW'(in_ready), 0);
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("rst_flush_out_valid", DW'(out_valid), 0);
    check("rst_flush_result", result, 0);
    check("rst_flush_tag", DW'(out_tag), 0);
    check("rst_flush_err", DW'(out_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(NS + 4);
    check("rst_flush_no_output", DW'(emitted - e0), 0);

    // Pipe still works after the mid-flight reset
    issue(4'b0001, 1, 0, 0, 64'hFF, 64'h02, 8'h77, 64'h01, 0, 1);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
    check("final_drained", DW'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_v_mul_pipe.md
Name: riscv_v_mul_pipe

Overview:
Pipelined, parametrised successor to the combinational vector multiplier for the RISC-V V datapath. It adds a valid/ready handshake, a configurable stage count with per-stage bubble collapse, and independent source signedness (vmul, vmulh, vmulhu, vmulhsu). A sideband tag travels with each operation, and malformed element-size selects are flagged. It sits between the vector issue stage and the result writeback mux.

Parameters:
DATA_WIDTH, 64, vector datapath width in bits; power of two, at least 64.
NUM_OSIZES, 4, number of supported element widths: 8, 16, 32 and 64 bits (element width EW = 8*2^k).
NUM_STAGES, 3, pipeline depth; must be at least 1; equals input-to-output latency when not stalled.
TAG_WIDTH, 8, width of the sideband tag passed through unchanged.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation presented on the input.
in_ready  output  1  block accepts the input this cycle.
is_high  input  1  1 selects the upper EW bits of each 2*EW product; 0 selects the lower EW bits.
srca_signed  input  1  treat srca elements as two's complement.
srcb_signed  input  1  treat srcb elements as two's complement.
osize_vector  input  NUM_OSIZES  one-hot element-width select; bit k selects EW = 8*2^k.
srca  input  DATA_WIDTH  multiplicand vector.
srcb  input  DATA_WIDTH  multiplier vector.
in_tag  input  TAG_WIDTH  sideband tag.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
result  output  DATA_WIDTH  packed per-element results.
out_tag  output  TAG_WIDTH  tag captured with the operation.
out_err  output  1  osize_vector was not one-hot for this operation.

Behaviour:
- Handshake: an operation transfers in when in_valid & in_ready, and out when out_valid & out_ready. out_valid is the valid bit of the last stage.
- Stage advance: stage i advances when stage i+1 is empty or advancing; the last stage advances when out_ready is high. in_ready = stage 0 empty or stage 0 advancing, so in_ready is combinational from out_ready through the chain.
- Empty stages capture nothing. Data registers of invalid stages hold their previous value.
- Latency: with out_ready held high, a result appears exactly NUM_STAGES cycles after acceptance. Throughput is 1 operation per cycle.
- Bubbles collapse: an empty middle stage is filled even while out_ready is low.
- Stall: while out_valid & !out_ready, result, out_tag and out_err are stable.
- Arithmetic, per element e of width EW:
  - Extend each operand to EW+1 bits: sign-extend when the corresponding *_signed bit is 1, zero-extend otherwise.
  - Form the signed (2*EW+2)-bit product; keep bits [2*EW-1:0].
  - result element e = bits [EW-1:0] when is_high = 0, bits [2*EW-1:EW] when is_high = 1.
  - The low half is independent of signedness.
- Partitioning: partial products may be split across stages freely, but the result must be bit-exact with the rule above.
- Error handling: an osize_vector that is zero or has more than one bit set gives result = 0 and out_err = 1; the operation still flows and its tag is preserved.
- Reset: all stage valid bits are cleared, so out_valid = 0, result = 0, out_tag = 0, out_err = 0. in_ready = 1 in the cycle after rst deasserts.
- Reset mid-operation: in-flight operations are discarded with no output. Input presented during rst is not accepted; in_ready = 0 while rst = 1.
- Simultaneous events: when the pipe is full and out_ready = 1, a new input is accepted in the same cycle as the output transfer, so no bubble is inserted.

Test Plan:
1. EW=8, srca byte0 = 0xFF, srcb byte0 = 0x02, is_high = 1, both signed -> byte0 = 0xFF. Both unsigned -> 0x01. a signed, b unsigned -> 0xFF. is_high = 0 -> 0xFE in all three modes.
2. EW=32, srca = srcb = 0x00010000_00010000, is_high = 0 -> result = 0. is_high = 1 -> result = 0x00000001_00000001.
3. EW=64, both signed, srca = 0x8000000000000000, srcb = 0xFFFFFFFFFFFFFFFF (-1), is_high = 1 -> 0x0000000000000000; is_high = 0 -> 0x8000000000000000.
4. Stream of 10 back-to-back ops with tags 0..9. Hold out_ready low for cycles 4-7 -> in_ready falls only after NUM_STAGES ops are buffered. Outputs are in order, nothing is lost or duplicated, and the stalled output holds steady.
5. osize_vector = 4'b0101 with tag 0x5A -> out_err = 1, result = 0, out_tag = 0x5A after NUM_STAGES cycles.
6. Assert rst with 2 ops in flight -> next cycle out_valid = 0, both ops are never emitted, and outputs read 0.
